// File: rtl/tvout_gen.sv
// tvout_gen: composite PAL-style video generator with framebuffer fetch and stripe test pattern.
// Ports:
//   clk_in      system clock
//   rst         asynchronous active-high reset
//   pattern_en  1 = stripe test pattern (latched at line start), no fetches
//   pix_rd      one-clk_in read strobe, high only in ce cycles
//   pix_addr    framebuffer byte address, valid while pix_rd = 1
//   pix_data    read data, sampled on the tick after the strobe
//   frame_start pulse on the ce that enters line 0
//   line_start  pulse on the ce that enters h = 0
//   tvout       bit0 = sync level (0 = tip), bits[BPP:1] = luma
module tvout_gen #(
    parameter int CLK_DIV     = 3,
    parameter int H_TOTAL     = 512,
    parameter int H_SYNC      = 37,
    parameter int H_EQ        = 16,
    parameter int ACT_START   = 117,
    parameter int ACT_WIDTH   = 320,
    parameter int V_TOTAL     = 311,
    parameter int V_BLANK_TOP = 5,
    parameter int V_BLANK_BOT = 2,
    parameter int V_ACT_START = 40,
    parameter int V_ACT_LINES = 200,
    parameter int BPP         = 1,
    parameter int ADDR_W      = 14
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              pattern_en,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic              frame_start,
    output logic              line_start,
    output logic [BPP:0]      tvout
);
    localparam int PPB    = 8 / BPP;
    localparam int GROUPS = ACT_WIDTH / PPB;
    localparam int HW     = $clog2(H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);
    localparam int DW     = $clog2(CLK_DIV);

    logic [DW-1:0]     div;
    logic [HW-1:0]     h, hn;
    logic [VW-1:0]     v, vn;
    logic [7:0]        hold, shifter;
    logic [ADDR_W-1:0] line_base, col;
    logic [BPP-1:0]    luma;
    logic              mode, ce, vblank, sync_n, act_line, cur_act_line, act, grp_start, latch;
    int                hi, vi, rel;

    // Everything registered is computed from the position being entered (hn, vn),
    // so tvout shows the value for (h, v) from the ce that reaches it.
    always_comb begin
        ce           = div == DW'(CLK_DIV - 1);
        hn           = (h == HW'(H_TOTAL - 1)) ? '0 : h + 1'b1;
        vn           = (h == HW'(H_TOTAL - 1)) ? ((v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1) : v;
        hi           = 32'(hn);
        vi           = 32'(vn);
        rel          = hi - ACT_START + 2;
        vblank       = vi < V_BLANK_TOP || vi >= V_TOTAL - V_BLANK_BOT;
        sync_n       = !(vblank ? ((vi < 3 ? hi < H_TOTAL / 2 - H_EQ : hi < H_EQ) ||
                                   (hi >= H_TOTAL / 2 && hi < (vi < 2 ? H_TOTAL - H_EQ : H_TOTAL / 2 + H_EQ)))
                                : hi < H_SYNC);
        act_line     = !vblank && vi >= V_ACT_START && vi < V_ACT_START + V_ACT_LINES;
        cur_act_line = 32'(v) >= V_ACT_START && 32'(v) < V_ACT_START + V_ACT_LINES &&
                       32'(v) >= V_BLANK_TOP && 32'(v) < V_TOTAL - V_BLANK_BOT;
        act          = act_line && hi >= ACT_START && hi < ACT_START + ACT_WIDTH;
        grp_start    = (hi - ACT_START) % PPB == 0;
        pix_rd       = ce && act_line && !mode && rel >= 0 && rel < ACT_WIDTH && rel % PPB == 0;
        latch        = ce && act_line && !mode && rel > 0 && rel <= ACT_WIDTH && (rel - 1) % PPB == 0;
        luma         = !act ? '0 : mode ? {BPP{vn[1]}} : grp_start ? hold[7 -: BPP] : shifter[7 -: BPP];
        pix_addr     = line_base + col;
        line_start   = ce && hn == '0;
        frame_start  = line_start && vn == '0;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div       <= '0;
            h         <= '0;
            v         <= '0;
            tvout     <= '0;
            mode      <= 1'b0;
            hold      <= '0;
            shifter   <= '0;
            line_base <= '0;
            col       <= '0;
        end else begin
            div <= ce ? '0 : div + 1'b1;
            if (ce) begin
                h     <= hn;
                v     <= vn;
                tvout <= {luma, sync_n};
                if (hn == '0) begin
                    mode      <= pattern_en;
                    col       <= '0;
                    line_base <= (vn == '0) ? '0 : cur_act_line ? line_base + ADDR_W'(GROUPS) : line_base;
                end else if (pix_rd) begin
                    col <= col + 1'b1;
                end
                if (latch)
                    hold <= pix_data;
                if (act && !mode)
                    shifter <= grp_start ? hold << BPP : shifter << BPP;
            end
        end
    end
endmodule

// File: tb/tb_tvout_gen.sv
// tb_tvout_gen: random-pattern bench comparing a 1 bpp and a 2 bpp tvout_gen against a frame-position model.
module tb_tvout_gen;
    localparam int CD = 2, HT = 64, HS = 5, HE = 3, AS = 8, AWD = 48;
    localparam int VT = 20, VBT = 5, VBB = 2, VAS = 6, VAL = 10;

    logic       clk_in = 1'b0, rst = 1'b1, pattern_en = 1'b0;
    logic       rd1, rd2, fs1, fs2, ls1, ls2;
    logic [4:0] addr1;
    logic [5:0] addr2;
    logic [7:0] data1 = '0, data2 = '0;
    logic [1:0] tv1;
    logic [2:0] tv2;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    bit         model_mode = 1'b0;
    int unsigned seed;

    always #5 clk_in = ~clk_in;

    tvout_gen #(.CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_EQ(HE), .ACT_START(AS), .ACT_WIDTH(AWD),
                .V_TOTAL(VT), .V_BLANK_TOP(VBT), .V_BLANK_BOT(VBB), .V_ACT_START(VAS),
                .V_ACT_LINES(VAL), .BPP(1), .ADDR_W(5)) dut1 (
        .clk_in(clk_in), .rst(rst), .pattern_en(pattern_en), .pix_rd(rd1), .pix_addr(addr1),
        .pix_data(data1), .frame_start(fs1), .line_start(ls1), .tvout(tv1));

    tvout_gen #(.CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_EQ(HE), .ACT_START(AS), .ACT_WIDTH(AWD),
                .V_TOTAL(VT), .V_BLANK_TOP(VBT), .V_BLANK_BOT(VBB), .V_ACT_START(VAS),
                .V_ACT_LINES(VAL), .BPP(2), .ADDR_W(6)) dut2 (
        .clk_in(clk_in), .rst(rst), .pattern_en(pattern_en), .pix_rd(rd2), .pix_addr(addr2),
        .pix_data(data2), .frame_start(fs2), .line_start(ls2), .tvout(tv2));

    function automatic logic [7:0] mem(input int a);
        return 8'((a * 73 + int'(seed)) & 255);
    endfunction

    function automatic bit vblank(input int v);
        return v < VBT || v >= VT - VBB;
    endfunction

    function automatic bit sync_low(input int h, input int v);
        if (!vblank(v)) return h < HS;
        if (v <= 1) return h < HT / 2 - HE || (h >= HT / 2 && h < HT - HE);
        if (v == 2) return h < HT / 2 - HE || (h >= HT / 2 && h < HT / 2 + HE);
        return h < HE || (h >= HT / 2 && h < HT / 2 + HE);
    endfunction

    function automatic bit act_line(input int v);
        return !vblank(v) && v >= VAS && v < VAS + VAL;
    endfunction

    function automatic int exp_tv(input int h, input int v, input int bpp, input int aw);
        int ppb, luma, k, j, b;
        ppb  = 8 / bpp;
        luma = 0;
        if (act_line(v) && h >= AS && h < AS + AWD) begin
            if (model_mode) begin
                luma = v[1] ? (1 << bpp) - 1 : 0;
            end else begin
                k    = (h - AS) / ppb;
                j    = (h - AS) % ppb;
                b    = int'(mem(((v - VAS) * (AWD / ppb) + k) % (1 << aw)));
                luma = (b >> (8 - bpp * (j + 1))) & ((1 << bpp) - 1);
            end
        end
        return luma * 2 + (sync_low(h, v) ? 0 : 1);
    endfunction

    function automatic int fetch_addr(input int h, input int v, input int bpp, input int aw);
        int ppb, rel;
        ppb = 8 / bpp;
        rel = h - AS + 2;
        if (!act_line(v) || model_mode || rel < 0 || rel >= AWD || rel % ppb != 0) return -1;
        return ((v - VAS) * (AWD / ppb) + rel / ppb) % (1 << aw);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d, time %0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tvout"}, 32'({tv2, tv1}), 32'd0);
        chk({tag, "_strobes"}, 32'({rd1, rd2, ls1, ls2, fs1, fs2}), 32'd0);
        chk({tag, "_addr"}, 32'({addr2, addr1}), 32'd0);
    endtask

    // One clk_in cycle: check the state entered at this edge and the strobes of the cycle that follows.
    task automatic step();
        int t, h, v, nh, nv, fa1, fa2;
        bit ce;
        @(posedge clk_in);
        cyc++;
        #1;
        t  = cyc / CD;
        h  = (t % (HT * VT)) % HT;
        v  = (t % (HT * VT)) / HT;
        nh = ((t + 1) % (HT * VT)) % HT;
        nv = ((t + 1) % (HT * VT)) / HT;
        ce = (cyc % CD) == CD - 1;
        if (cyc % CD == 0) begin
            chk("tvout_bpp1", 32'(tv1), exp_tv(h, v, 1, 5));
            chk("tvout_bpp2", 32'(tv2), exp_tv(h, v, 2, 6));
        end
        fa1 = fetch_addr(nh, nv, 1, 5);
        fa2 = fetch_addr(nh, nv, 2, 6);
        chk("strobes_bpp1", 32'({rd1, ls1, fs1}), 32'({ce && fa1 >= 0, ce && nh == 0, ce && nh == 0 && nv == 0}));
        chk("strobes_bpp2", 32'({rd2, ls2, fs2}), 32'({ce && fa2 >= 0, ce && nh == 0, ce && nh == 0 && nv == 0}));
        if (ce && fa1 >= 0) chk("addr_bpp1", 32'(addr1), fa1);
        if (ce && fa2 >= 0) chk("addr_bpp2", 32'(addr2), fa2);
        if (ce && nh == 0) model_mode = pattern_en;
        if (!ce && $urandom_range(0, 299) == 0) pattern_en = ~pattern_en;
    endtask

    initial begin
        logic [4:0] a;
        forever begin
            @(negedge clk_in);
            if (rd1) begin
                a = addr1;
                @(posedge clk_in);
                #1 data1 = mem(int'(a));
            end
        end
    end

    initial begin
        logic [5:0] a;
        forever begin
            @(negedge clk_in);
            if (rd2) begin
                a = addr2;
                @(posedge clk_in);
                #1 data2 = mem(int'(a));
            end
        end
    end

    initial begin
        seed = $urandom;
        repeat (3) @(posedge clk_in);
        #1 reset_checks("por");
        @(negedge clk_in);
        rst = 1'b0;
        cyc = 0;
        model_mode = 1'b0;
        repeat (3 * HT * VT * CD + $urandom_range(0, HT * VT * CD - 1)) step();
        #2 rst = 1'b1;
        #1 reset_checks("async_rst");
        repeat (5) @(posedge clk_in);
        #1 reset_checks("held_rst");
        @(negedge clk_in);
        rst = 1'b0;
        cyc = 0;
        model_mode = 1'b0;
        repeat (2 * HT * VT * CD) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tvout_gen.md
# tvout_gen

Parametrised composite (PAL-style) video generator. It drives the two-resistor `tvout` DAC pins with a configurable line and frame timing. Vertical sync uses proper broad and equalising pulses. Active-area pixels are fetched from a byte-wide framebuffer port, at 1 or 2 bits per pixel. It sits between the system clock domain's video RAM and the TV connector, and adds a built-in stripe test-pattern mode.

## Interface
Parameters:
- `CLK_DIV`, 3: clk_in cycles per video tick (≥2).
- `H_TOTAL`, 512: ticks per line (even).
- `H_SYNC`, 37: line sync pulse width, ticks.
- `H_EQ`, 16: equalising pulse width, ticks.
- `ACT_START`, 117: first active tick of a line (≥ H_SYNC+2).
- `ACT_WIDTH`, 320: active ticks per line (multiple of PPB).
- `V_TOTAL`, 311: lines per frame.
- `V_BLANK_TOP`, 5: vblank lines at frame start.
- `V_BLANK_BOT`, 2: vblank lines at frame end.
- `V_ACT_START`, 40: first active line.
- `V_ACT_LINES`, 200: active lines.
- `BPP`, 1: bits per pixel, 1 or 2; PPB = 8/BPP.
- `ADDR_W`, 14: framebuffer address width.

Ports:
- `clk_in`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pattern_en`  in  1  1 = stripe test pattern, no fetches.
- `pix_rd`  out  1  one-clk_in read strobe.
- `pix_addr`  out  ADDR_W  byte address, valid while pix_rd = 1.
- `pix_data`  in  8  read data, sampled on the next tick (≥2 clk_in cycles after the strobe).
- `frame_start`  out  1  one-cycle pulse at the start of line 0.
- `line_start`  out  1  one-cycle pulse at the start of every line.
- `tvout`  out  BPP+1  bit0 = sync level (0 = sync tip); bits[BPP:1] = luma.

## Operation
- Tick enable `ce`: a divider counts 0..CLK_DIV-1, and `ce` is high for one clk_in cycle when the count is CLK_DIV-1. All state below updates only on `ce`. `pix_rd`, `frame_start` and `line_start` are high only in `ce` cycles.
- Counters: `h` runs 0..H_TOTAL-1. On the wrap, `v` increments over 0..V_TOTAL-1 and wraps to 0.
- vblank = v < V_BLANK_TOP or v ≥ V_TOTAL-V_BLANK_BOT. Luma is 0 throughout vblank.
- Sync (bit0 = 0 when):
  - Visible lines: h < H_SYNC.
  - vblank lines v = 0, 1: h < H_TOTAL/2-H_EQ or H_TOTAL/2 ≤ h < H_TOTAL-H_EQ (broad pulses).
  - vblank line v = 2: h < H_TOTAL/2-H_EQ or H_TOTAL/2 ≤ h < H_TOTAL/2+H_EQ.
  - Other vblank lines: h < H_EQ or H_TOTAL/2 ≤ h < H_TOTAL/2+H_EQ (equalising).
- Active = V_ACT_START ≤ v < V_ACT_START+V_ACT_LINES and ACT_START ≤ h < ACT_START+ACT_WIDTH. Outside active, luma is 0 and bit0 follows sync.
- Fetch, for group k = 0..ACT_WIDTH/PPB-1 on an active line with pattern_en = 0:
  - pix_rd with pix_addr = line_base+k at h = ACT_START+k·PPB-2.
  - pix_data latched into hold at h = ACT_START+k·PPB-1.
  - hold loaded into the shifter at h = ACT_START+k·PPB.
  - Pixels are output MSB-first, BPP bits per tick.
- line_base resets to 0 at v = 0, h = 0. It adds ACT_WIDTH/PPB at the end of each active line. Arithmetic is modulo 2^ADDR_W; wrap is silent.
- Pattern mode: luma = {BPP{v[1]}} in active ticks, and no pix_rd is issued. A change of pattern_en takes effect at the next line start.

## Timing
- `tvout` is registered and updated on `ce`. The value for counter state (h, v) is driven from that `ce` until the next one.
- Reset (async assert) clears the divider, h, v, line_base, hold, shifter and the latched mode. `tvout` = 0, `pix_rd` = 0, `pix_addr` = 0, pulses = 0. The first `ce` occurs CLK_DIV cycles after rst deasserts.
- Reset mid-line aborts any fetch in flight. A late pix_data is ignored.
- `frame_start` and `line_start` assert on the `ce` on which h becomes 0 (frame_start also requires v = 0). They are not asserted on the first tick after reset.
- The first fetch of a line at h = ACT_START-2 never overlaps sync, because ACT_START ≥ H_SYNC+2.

## Test plan
- Defaults, run 2 frames: line_start every 1536 clk_in cycles; frame_start every 311 lines; bit0 low 37 ticks on v = 10.
- vsync shape: v = 0 shows lows at h 0..239 and 256..495; v = 2 at 0..239 and 256..271; v = 3 at 0..15 and 256..271; v = 309 equalising; luma 0 throughout.
- Fetch, BPP=1, memory returns addr[7:0]: v = 40 issues 40 reads with addr 0..39 at h = 115+8k; v = 41 starts at addr 40; tvout[1] at h = 117+8+j equals bit 7-j of byte 1.
- BPP=2: 80 reads per line; each byte spans 4 ticks; tvout[2:1] follows bits 7:6, 5:4, 3:2, 1:0.
- pattern_en = 1 from line 50: no pix_rd from line 50 onward; tvout[1] = v[1] during active ticks.
- Assert rst at v = 100, h = 200 for 5 cycles: all outputs 0 immediately (async); after release h = v = 0, and first line_start at v = 1.
